// File: rtl/stonet_synapse_feeder.sv
// stonet_synapse_feeder: per-block sequencer feeding the stochastic hidden neuron.
// It latches the input spike vector, streams 4-lane weight quads from RAM, gates
// each lane by its spike bit, drains the adder pipeline, holds gen_spike, and then
// closes the block with new_block/done.
// Optional feature: define FEEDER_SKIP_ZERO_EN to skip quads whose 4 spikes are all 0.
module stonet_synapse_feeder #(
  parameter int unsigned N_IN         = 196,
  parameter int unsigned AW           = 6,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned GEN_CYCLES   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N_IN-1:0] in_spikes,
  output logic            w_ren,
  output logic [AW-1:0]   w_addr,
  input  logic [35:0]     w_rdata,
  output logic [8:0]      weight0,
  output logic [8:0]      weight1,
  output logic [8:0]      weight2,
  output logic [8:0]      weight3,
  output logic            gen_spike,
  output logic            new_block,
  output logic            busy,
  output logic            done
);

  localparam int unsigned QUADS = N_IN / 4;
  localparam int unsigned CMAX  = (DRAIN_CYCLES > GEN_CYCLES) ? DRAIN_CYCLES : GEN_CYCLES;
  localparam int unsigned CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StGen, StClose} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   q_q, q_d;
  logic [N_IN-1:0] spk_q, spk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      lane_spk_q;
  logic            lane_vld_q;
  logic [3:0][8:0] wt_q;
  logic [3:0]      spk_slice;

`ifdef FEEDER_SKIP_ZERO_EN
  // Returns {found, index} of the first quad at or after 'from' with any spike set.
  function automatic logic [AW:0] find_nz(input logic [N_IN-1:0] v, input int unsigned from);
    logic [AW:0] r;
    r = '0;
    for (int unsigned i = 0; i < QUADS; i++) begin
      if (!r[AW] && (i >= from) && (v[4*i +: 4] != 4'b0000)) begin
        r = {1'b1, AW'(i)};
      end
    end
    return r;
  endfunction

  logic [AW:0] first_nz;
  logic [AW:0] next_nz;
  assign first_nz = find_nz(in_spikes, 0);
  assign next_nz  = find_nz(spk_q, 32'(q_q) + 32'd1);
`else
  localparam logic [AW-1:0] LastQuad = AW'(QUADS - 1);
`endif

  // Next-state logic for the block sequencer.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    spk_d   = spk_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          spk_d = in_spikes;
          cnt_d = '0;
`ifdef FEEDER_SKIP_ZERO_EN
          if (first_nz[AW]) begin
            q_d     = first_nz[AW-1:0];
            state_d = StFetch;
          end else begin
            q_d     = '0;
            state_d = StDrain;
          end
`else
          q_d     = '0;
          state_d = StFetch;
`endif
        end
      end
      StFetch: begin
`ifdef FEEDER_SKIP_ZERO_EN
        if (next_nz[AW]) begin
          q_d = next_nz[AW-1:0];
        end else begin
          cnt_d   = '0;
          state_d = StDrain;
        end
`else
        if (q_q == LastQuad) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          q_d = q_q + 1'b1;
        end
`endif
      end
      StDrain: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StGen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGen: begin
        if (cnt_q == CW'(GEN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StClose;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClose: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state, quad counter, phase counter and latched spikes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      spk_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      spk_q   <= spk_d;
      cnt_q   <= cnt_d;
    end
  end

  // Spike bits of the quad being addressed this cycle.
  always_comb begin
    spk_slice = 4'(spk_q >> {q_q, 2'b00});
  end

  // Spike slice is delayed one cycle to line up with w_rdata, then lanes are gated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_vld_q <= 1'b0;
      lane_spk_q <= '0;
      wt_q       <= '0;
    end else begin
      lane_vld_q <= w_ren;
      lane_spk_q <= w_ren ? spk_slice : 4'b0000;
      for (int n = 0; n < 4; n++) begin
        wt_q[n] <= (lane_vld_q && lane_spk_q[n]) ? w_rdata[9*n +: 9] : 9'd0;
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    w_ren     = (state_q == StFetch);
    w_addr    = w_ren ? q_q : '0;
    gen_spike = (state_q == StGen);
    new_block = (state_q == StClose);
    done      = (state_q == StClose);
    busy      = (state_q != StIdle);
  end

  assign weight0 = wt_q[0];
  assign weight1 = wt_q[1];
  assign weight2 = wt_q[2];
  assign weight3 = wt_q[3];

endmodule

// File: tb/tb_stonet_synapse_feeder.sv
// Self-checking bench for stonet_synapse_feeder: random spikes and RAM contents,
// checked cycle by cycle against a per-block expected trace built from the fetch list.
module tb_stonet_synapse_feeder;
  localparam int unsigned N_IN = 196;
  localparam int unsigned AW   = 6;
  localparam int unsigned D    = 5;
  localparam int unsigned G    = 3;
  localparam int unsigned Q    = N_IN / 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [N_IN-1:0] in_spikes;
  logic            w_ren;
  logic [AW-1:0]   w_addr;
  logic [35:0]     w_rdata;
  logic [8:0]      weight0, weight1, weight2, weight3;
  logic            gen_spike, new_block, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] ram [2**AW];

  stonet_synapse_feeder #(
    .N_IN(N_IN), .AW(AW), .DRAIN_CYCLES(D), .GEN_CYCLES(G)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_spikes(in_spikes),
    .w_ren(w_ren), .w_addr(w_addr), .w_rdata(w_rdata),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .gen_spike(gen_spike), .new_block(new_block), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered-read RAM; junk on the bus when not reading so gating is exercised.
  always @(posedge clk) begin
    if (w_ren) w_rdata <= ram[w_addr];
    else       w_rdata <= 36'({$urandom, $urandom});
  end

  task automatic fill_ram_random();
    for (int i = 0; i < 2**AW; i++) ram[i] = 36'({$urandom, $urandom});
  endtask

  function automatic logic [N_IN-1:0] rand_spikes();
    logic [N_IN-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  // One full block from cycle 0 (start sampled) to its close cycle. s1/s2 are extra
  // start pulses (-1 none, -2 = close cycle); rc is a reset cycle (-1 none).
  task automatic run_block(input logic [N_IN-1:0] spk, input int s1, input int s2,
                           input int rc);
    int f[$];
    int p, last, j, fq;
    logic [4:0]    exp_ctl, got_ctl;
    logic [AW-1:0] exp_addr;
    logic [35:0]   exp_w, got_w;
    for (int q = 0; q < int'(Q); q++) begin
`ifdef FEEDER_SKIP_ZERO_EN
      if (spk[4*q +: 4] != 4'b0000) f.push_back(q);
`else
      f.push_back(q);
`endif
    end
    p    = f.size();
    last = p + D + G + 1;
    for (int c = 0; c <= last; c++) begin
      start     = (c == 0) || (c == s1) || (c == (s2 == -2 ? last : s2));
      in_spikes = (c == 0) ? spk : rand_spikes();
      reset     = (c == rc);
      @(negedge clk);
      exp_ctl  = '0;
      exp_addr = '0;
      exp_w    = '0;
      if (rc < 0 || c < rc) begin
        exp_ctl[4] = (c >= 1) && (c <= p);
        if (exp_ctl[4]) exp_addr = AW'(f[c-1]);
        exp_ctl[3] = (c >= p + D + 1) && (c <= p + D + G);
        exp_ctl[2] = (c == last);
        exp_ctl[1] = (c == last);
        exp_ctl[0] = (c >= 1) && (c <= last);
        j = c - 3;
        if (j >= 0 && j < p) begin
          fq = f[j];
          for (int n = 0; n < 4; n++)
            if (spk[4*fq + n]) exp_w[9*n +: 9] = ram[fq][9*n +: 9];
        end
      end
      got_ctl = {w_ren, gen_spike, new_block, done, busy};
      got_w   = {weight3, weight2, weight1, weight0};
      n_checks++;
      if (got_ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL ctl cycle %0d: got ren/gen/nb/done/busy=%b want %b", c, got_ctl, exp_ctl);
      end
      n_checks++;
      if (w_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL w_addr cycle %0d: got %0d want %0d", c, w_addr, exp_addr);
      end
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL weights cycle %0d: got %h want %h", c, got_w, exp_w);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_spikes = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({w_ren, w_addr, weight0, weight1, weight2, weight3, gen_spike, new_block, busy, done}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ren=%b addr=%0d busy=%b nb=%b want all 0",
               w_ren, w_addr, busy, new_block);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({w_ren, busy, done, gen_spike} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got ren/busy/done/gen=%b want 0000",
               {w_ren, busy, done, gen_spike});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    for (int q = 0; q < 2**AW; q++)
      ram[q] = {9'(4*q+3), 9'(4*q+2), 9'(4*q+1), 9'(4*q)};
    run_block({N_IN{1'b1}}, -1, -1, -1);
  endtask

  task automatic test_single_spike();
    logic [N_IN-1:0] s;
    fill_ram_random();
    s    = '0;
    s[5] = 1'b1;
    run_block(s, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      fill_ram_random();
      run_block((k == 0) ? rand_spikes() : (rand_spikes() & rand_spikes() & rand_spikes()),
                -1, -1, -1);
    end
  endtask

  task automatic test_zero_spikes();
    fill_ram_random();
    run_block('0, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    fill_ram_random();
    run_block(rand_spikes(), 10, -2, -1);
    run_block(rand_spikes(), -1, -1, -1);
  endtask

  task automatic test_reset_mid();
    fill_ram_random();
    run_block({N_IN{1'b1}}, -1, -1, 20);
    run_block(rand_spikes(), -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_spike();
    test_random();
    test_zero_spikes();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
